rtype_issue: RTL and testbench
==============================

Name: rtype_issue

Overview:
- Producer end of the R-type instruction interface consumed by the `rtype` datapath.
- Accepts decoded instruction fields over a valid/ready handshake and encodes them into 32-bit MIPS R-type words.
- Buffers the words in a small FIFO and presents them, one per clock, on an `instruction` output that drives the datapath's `instruction` input directly.
- Replaces hand-written instruction sequences in benches and sits in front of the datapath in the integrated design.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- NOP_WORD, 32'h0000_0000, word driven when nothing is issued.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  field tuple present.
- in_ready  out  1  block can accept a tuple this cycle.
- in_rs  in  5  source register rs.
- in_rt  in  5  source register rt.
- in_rd  in  5  destination register rd.
- in_shamt  in  5  shift amount.
- in_funct  in  6  function code.
- hold  in  1  downstream stall.
- instruction  out  32  issued word (registered).
- issue_valid  out  1  `instruction` holds a real issued word (registered).
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- drop_err  out  1  one-cycle pulse when an illegal funct is dropped.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - `fifo_count` = 0; read and write pointers = 0.
  - `instruction` = NOP_WORD; `issue_valid` = 0; `drop_err` = 0.
  - Reset mid-operation discards all buffered words; nothing is issued on the following cycle.
- Encoding: word = {6'b000000, rs, rt, rd, shamt, funct}. Opcode is always 0.
  - Example: rs=13, rt=8, rd=16, shamt=0, funct=0x20 encodes to 32'h01A8_8020.
- Legal funct set: 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu.
- Accept rule:
  - A transfer occurs when in_valid && in_ready.
  - in_ready = (fifo_count != DEPTH). It is combinational from the count and does not depend on in_valid.
  - A full FIFO never accepts, even if a pop happens in the same cycle.
- Illegal funct on an accepted transfer:
  - Nothing is written to the FIFO.
  - drop_err = 1 for exactly the next cycle.
  - Occupancy is unaffected except by any concurrent pop.
- Issue FSM, registered outputs:
  - IDLE: issue_valid = 0, instruction = NOP_WORD.
    - If hold = 0 and the FIFO is non-empty: pop the head into `instruction`, set issue_valid = 1, go to ISSUE.
  - ISSUE:
    - hold = 1: go to HELD; outputs unchanged.
    - hold = 0 and FIFO non-empty: pop the next word, stay in ISSUE.
    - hold = 0 and FIFO empty: instruction = NOP_WORD, issue_valid = 0, go to IDLE.
  - HELD: outputs and FIFO head frozen while hold = 1. When hold = 0, act as ISSUE with hold = 0.
  - hold in IDLE: no pop; stay in IDLE.
- Latency: a tuple accepted at edge E into an empty FIFO with hold = 0 appears on `instruction` with issue_valid = 1 after edge E+1. Sustained throughput is 1 word per cycle.
- Simultaneous push and pop: count unchanged. Pointers advance modulo DEPTH, wrapping silently.
- A word pushed into an empty FIFO is not bypassed to the output in the same cycle.
- fifo_count never exceeds DEPTH and never underflows; the bench asserts both.

Decomposition:
- Shared package `rtype_pkg`:
  - OPCODE_RTYPE.
  - Field widths and bit positions (rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0).
  - FUNCT_* constants.
  - Function `funct_legal`.
  - Issue-FSM state enum.
- Sub-module `rtype_fifo`:
  - Synchronous, parameterised by DEPTH and width.
  - push/pop/full/empty/count interface.
  - Instantiated once; encoding, legality check and the issue FSM stay in `rtype_issue`.

Test Plan:
- Basic issue: after reset, push (13,8,16,0,0x20), then (14,9,17,0,0x22) back-to-back with hold = 0.
  - `instruction` = 01A88020, then 01C98822, on consecutive cycles with issue_valid = 1.
  - Next cycle: issue_valid = 0, instruction = 0.
- Fill and back-pressure: hold = 1, push 5 legal tuples with DEPTH = 4.
  - in_ready drops after the 4th accept and fifo_count = 4.
  - The 5th tuple is held by the source.
  - Release hold: 4 words issue in push order, then the 5th.
- Hold mid-stream: assert hold for 3 cycles while in ISSUE.
  - `instruction` and issue_valid are frozen for 3 cycles.
  - No word is lost or duplicated after release.
- Illegal funct: push funct = 0x3F, then a legal add.
  - drop_err pulses for 1 cycle; fifo_count stays 0.
  - Only the add (e.g. 01A88020) issues.
- Reset mid-operation: with 3 words buffered and one issuing, pulse reset for 1 cycle.
  - Next cycle: fifo_count = 0, issue_valid = 0, instruction = 0, in_ready = 1.
  - No stale word ever issues.
- Wrap-around: stream 10 tuples with simultaneous push/pop and DEPTH = 4.
  - Issued sequence matches pushed sequence exactly.
  - fifo_count stays ≤ 1.

Source files
------------

// File: rtl/rtype_pkg.sv
// ----------------------------------------------------------------------------
// rtype_pkg
//
// Shared definitions for the R-type instruction issue block:
//   - opcode, field widths and bit positions of a MIPS R-type word
//   - function codes for the supported ALU operations
//   - funct_legal(): returns 1 when a funct code is in the supported set
//   - issue_state_e: states of the issue FSM in rtype_issue
// ----------------------------------------------------------------------------
package rtype_pkg;

  // Opcode field; every R-type word carries zero here.
  localparam logic [5:0] OPCODE_RTYPE = 6'b00_0000;

  // Field widths.
  localparam int OPCODE_W = 6;
  localparam int RS_W     = 5;
  localparam int RT_W     = 5;
  localparam int RD_W     = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int WORD_W   = 32;

  // Field bit positions (LSB of each field within the 32-bit word).
  localparam int OPCODE_LSB = 26;  // 31:26
  localparam int RS_LSB     = 21;  // 25:21
  localparam int RT_LSB     = 16;  // 20:16
  localparam int RD_LSB     = 11;  // 15:11
  localparam int SHAMT_LSB  = 6;   // 10:6
  localparam int FUNCT_LSB  = 0;   // 5:0

  // Supported function codes.
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  // True when the datapath implements this funct code.
  function automatic logic funct_legal(input logic [FUNCT_W-1:0] funct);
    logic legal;
    unique case (funct)
      FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
      FUNCT_AND, FUNCT_OR,   FUNCT_XOR, FUNCT_NOR,
      FUNCT_SLT, FUNCT_SLTU: legal = 1'b1;
      default:               legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Issue FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // nothing on the output, waiting for a word
    ST_ISSUE = 2'd1,  // a real word is on the output, hold is low
    ST_HELD  = 2'd2   // a real word is frozen on the output by hold
  } issue_state_e;

endpackage : rtype_pkg

// File: rtl/rtype_fifo.sv
// ----------------------------------------------------------------------------
// rtype_fifo
//
// Synchronous single-clock FIFO with a combinational head read.
//
// Parameters:
//   DEPTH  number of entries; power of two, at least 2
//   WIDTH  entry width in bits
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data this cycle (ignored when full)
//   push_data  in   WIDTH  data to write
//   pop        in   drop the head entry this cycle (ignored when empty)
//   pop_data   out  WIDTH  current head entry (valid when !empty)
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  $clog2(DEPTH)+1  current occupancy
// ----------------------------------------------------------------------------
module rtype_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CNT_FULL);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];

  // Guard at the FIFO itself so a caller bug can never overflow or underflow.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop  && !empty;

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // modulo DEPTH simply by overflowing.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;  // idle, or push and pop together
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; entries are
  // only ever read after being written, and an unreset array maps to plain
  // RAM instead of a bank of resettable flops.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule : rtype_fifo

// File: rtl/rtype_issue.sv
// ----------------------------------------------------------------------------
// rtype_issue
//
// Producer end of the R-type instruction interface. Accepts decoded fields on
// a valid/ready handshake, encodes them into 32-bit MIPS R-type words, buffers
// them in a small FIFO and issues one word per clock on `instruction`, which
// drives the datapath's instruction input directly.
//
// Parameters:
//   DEPTH     FIFO entries; power of two, at least 2
//   NOP_WORD  word driven on `instruction` when nothing is issued
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset, highest priority
//   in_valid     in   field tuple present
//   in_ready     out  block can accept a tuple this cycle (from count only)
//   in_rs        in   5  source register rs
//   in_rt        in   5  source register rt
//   in_rd        in   5  destination register rd
//   in_shamt     in   5  shift amount
//   in_funct     in   6  function code
//   hold         in   downstream stall; freezes the issued word
//   instruction  out  32 issued word (registered)
//   issue_valid  out  `instruction` holds a real word (registered)
//   fifo_count   out  $clog2(DEPTH)+1  current FIFO occupancy
//   drop_err     out  one-cycle pulse after an illegal funct was dropped
// ----------------------------------------------------------------------------
module rtype_issue
  import rtype_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rs,
  input  logic [4:0]             in_rt,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_shamt,
  input  logic [5:0]             in_funct,
  input  logic                   hold,
  output logic [31:0]            instruction,
  output logic                   issue_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   drop_err
);

  // --------------------------------------------------------------------------
  // Encoding and acceptance
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] w_word;
  logic              w_legal;
  logic              w_xfer;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_head;

  always_comb begin
    w_word = '0;
    w_word[OPCODE_LSB +: OPCODE_W] = OPCODE_RTYPE;
    w_word[RS_LSB     +: RS_W]     = in_rs;
    w_word[RT_LSB     +: RT_W]     = in_rt;
    w_word[RD_LSB     +: RD_W]     = in_rd;
    w_word[SHAMT_LSB  +: SHAMT_W]  = in_shamt;
    w_word[FUNCT_LSB  +: FUNCT_W]  = in_funct;
  end

  assign w_legal = funct_legal(in_funct);

  // Ready depends only on occupancy (full == count reached DEPTH), so a full
  // FIFO refuses a tuple even in a cycle where the head is being popped.
  assign in_ready = !w_full;
  assign w_xfer   = in_valid && in_ready;

  // An accepted tuple with an unsupported funct is consumed but not stored.
  assign w_push   = w_xfer && w_legal;

  // The pop decision uses the pre-edge occupancy, so a word pushed into an
  // empty FIFO waits one cycle instead of being bypassed to the output.
  assign w_pop    = !hold && !w_empty;

  // --------------------------------------------------------------------------
  // Word buffer
  // --------------------------------------------------------------------------
  rtype_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_word),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count)
  );

  // --------------------------------------------------------------------------
  // Issue FSM with registered outputs
  // --------------------------------------------------------------------------
  issue_state_e r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      instruction <= NOP_WORD;
      issue_valid <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      drop_err <= w_xfer && !w_legal;

      unique case (r_state)
        ST_IDLE: begin
          // hold in IDLE simply keeps the NOP on the output.
          if (w_pop) begin
            instruction <= w_head;
            issue_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end

        // HELD with hold released behaves exactly like ISSUE.
        ST_ISSUE, ST_HELD: begin
          if (hold) begin
            r_state <= ST_HELD;
          end else if (!w_empty) begin
            instruction <= w_head;
            issue_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end else begin
            instruction <= NOP_WORD;
            issue_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          instruction <= NOP_WORD;
          issue_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : rtype_issue

// File: tb/tb_rtype_issue.sv
// ----------------------------------------------------------------------------
// tb_rtype_issue
//
// Directed bench for rtype_issue. A reference model of the expected buffer
// contents (a queue of encoded words) is updated from the stimulus on every
// clock; the DUT outputs are compared against it one time unit after each
// rising edge, together with explicit constant checks at key points.
// ----------------------------------------------------------------------------
module tb_rtype_issue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic        hold = 1'b0;
  logic [31:0] instruction;
  logic        issue_valid;
  logic [2:0]  fifo_count;
  logic        drop_err;

  rtype_issue #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_shamt    (in_shamt),
    .in_funct    (in_funct),
    .hold        (hold),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .fifo_count  (fifo_count),
    .drop_err    (drop_err)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [31:0] m_q[$];     // expected FIFO contents, head first
  logic [31:0] m_out = NOP;
  bit          m_valid = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_acc = 1'b0;   // last tick accepted a tuple

  logic [5:0] legal_f [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                               6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

  function automatic logic [31:0] enc(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic bit legal(input logic [5:0] fn);
    return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                      6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn);
    in_valid = 1'b1;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_shamt = sh;
    in_funct = fn;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  // Advance one clock: update the model from the current inputs, let the edge
  // happen, then compare every output against the model.
  task automatic tick();
    bit ready;
    bit pop;
    bit xfer;
    ready = (m_q.size() != DEPTH);
    m_acc = 1'b0;
    if (reset) begin
      m_q.delete();
      m_out   = NOP;
      m_valid = 1'b0;
      m_drop  = 1'b0;
    end else begin
      pop  = !hold && (m_q.size() != 0);
      xfer = in_valid && ready;
      if (pop) begin
        m_out   = m_q.pop_front();
        m_valid = 1'b1;
      end else if (!hold) begin
        m_out   = NOP;
        m_valid = 1'b0;
      end
      if (xfer && legal(in_funct))
        m_q.push_back(enc(in_rs, in_rt, in_rd, in_shamt, in_funct));
      m_drop = xfer && !legal(in_funct);
      m_acc  = xfer;
    end
    @(posedge clock);
    #1;
    check("instruction", instruction, m_out);
    check("issue_valid", 32'(issue_valid), 32'(m_valid));
    check("fifo_count",  32'(fifo_count), 32'(m_q.size()));
    check("drop_err",    32'(drop_err), 32'(m_drop));
    check("in_ready",    32'(in_ready), 32'(m_q.size() != DEPTH));
    check("count_bound", 32'(fifo_count <= 3'(DEPTH)), 32'd1);
  endtask

  logic [31:0] held_word;

  initial begin
    // ---------------- Reset ----------------
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(issue_valid), 32'd0);
    check("rst_instr", instruction, NOP);
    check("rst_ready", 32'(in_ready), 32'd1);

    // ---------------- Basic issue ----------------
    hold = 1'b0;
    drive(5'd13, 5'd8, 5'd16, 5'd0, 6'h20);
    tick();
    check("basic_nobypass", 32'(issue_valid), 32'd0);
    drive(5'd14, 5'd9, 5'd17, 5'd0, 6'h22);
    tick();
    check("basic_w0", instruction, 32'h01A8_8020);
    check("basic_v0", 32'(issue_valid), 32'd1);
    idle_in();
    tick();
    check("basic_w1", instruction, 32'h01C9_8822);
    tick();
    check("basic_end_v", 32'(issue_valid), 32'd0);
    check("basic_end_i", instruction, NOP);

    // ---------------- Fill and back-pressure ----------------
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(5'(i + 1), 5'(i + 2), 5'(i + 3), 5'(i), legal_f[i]);
      tick();
    end
    check("fill_count", 32'(fifo_count), 32'd4);
    check("fill_ready", 32'(in_ready), 32'd0);
    drive(5'd20, 5'd21, 5'd22, 5'd3, 6'h2A);
    tick();
    tick();
    check("fill_5th_held", 32'(fifo_count), 32'd4);
    hold = 1'b0;
    for (int n = 0; n < 20 && !m_acc; n++) tick();
    check("fill_5th_accept", 32'(m_acc), 32'd1);
    idle_in();
    for (int n = 0; n < 6; n++) tick();
    check("fill_drained", 32'(issue_valid), 32'd0);

    // ---------------- Hold mid-stream ----------------
    hold = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    tick();
    drive(5'd4, 5'd5, 5'd6, 5'd1, 6'h24);
    tick();
    drive(5'd7, 5'd8, 5'd9, 5'd2, 6'h27);
    tick();
    idle_in();
    hold = 1'b1;
    held_word = m_out;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("hold_frozen_i", instruction, held_word);
      check("hold_frozen_v", 32'(issue_valid), 32'd1);
    end
    hold = 1'b0;
    tick();
    check("hold_next", instruction, enc(5'd7, 5'd8, 5'd9, 5'd2, 6'h27));
    for (int n = 0; n < 3; n++) tick();

    // ---------------- Illegal funct ----------------
    drive(5'd13, 5'd8, 5'd16, 5'd0, 6'h3F);
    tick();
    check("ill_drop", 32'(drop_err), 32'd1);
    check("ill_count", 32'(fifo_count), 32'd0);
    drive(5'd13, 5'd8, 5'd16, 5'd0, 6'h20);
    tick();
    check("ill_drop_clear", 32'(drop_err), 32'd0);
    idle_in();
    tick();
    check("ill_add", instruction, 32'h01A8_8020);
    tick();
    tick();

    // ---------------- Reset mid-operation ----------------
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(5'(i + 10), 5'(i), 5'(i + 5), 5'd0, legal_f[i + 4]);
      tick();
    end
    hold = 1'b0;
    drive(5'd30, 5'd29, 5'd28, 5'd0, 6'h2B);
    tick();
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    check("pre_rst_valid", 32'(issue_valid), 32'd1);
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_valid", 32'(issue_valid), 32'd0);
    check("mid_rst_instr", instruction, NOP);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("no_stale", 32'(issue_valid), 32'd0);
    end

    // ---------------- Wrap-around streaming ----------------
    hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(5'(i), 5'(31 - i), 5'(i * 3), 5'(i), legal_f[i]);
      tick();
      check("wrap_count_le1", 32'(fifo_count <= 3'd1), 32'd1);
    end
    idle_in();
    for (int n = 0; n < 3; n++) tick();
    check("wrap_end", 32'(issue_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_rtype_issue
